// File: rtl/condicionador_botoes_pkg.sv
// rtl/condicionador_botoes_pkg.sv - shared state codes, defaults and helpers for button conditioning
package condicionador_botoes_pkg;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
   localparam int BOTOES_W                = 4;

   typedef enum logic [3:0] {
      OCIOSO        = 4'd0,
      REGISTRA      = 4'd1,
      INVALIDA      = 4'd2,
      ESPERA_SOLTAR = 4'd3
   } estado_t;

   function automatic logic is_one_hot(input logic [BOTOES_W-1:0] v);
      return (v != '0) && ((v & (v - BOTOES_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// rtl/condicionador_botoes_if.sv - control, raw button and play-event signals of the conditioner
interface condicionador_botoes_if;
   import condicionador_botoes_pkg::*;

   logic                habilita;
   logic                limpa;
   logic [BOTOES_W-1:0] botoes;
   logic [BOTOES_W-1:0] jogada;
   logic                jogada_feita;
   logic                jogada_invalida;
   logic [BOTOES_W-1:0] db_botoes_estaveis;
   logic [3:0]          db_estado;

   modport master (
      output habilita, limpa, botoes,
      input  jogada, jogada_feita, jogada_invalida, db_botoes_estaveis, db_estado
   );

   modport slave (
      input  habilita, limpa, botoes,
      output jogada, jogada_feita, jogada_invalida, db_botoes_estaveis, db_estado
   );

endinterface

// File: rtl/condicionador_botoes_debounce_vetor.sv
// rtl/condicionador_botoes_debounce_vetor.sv - two-flop synchroniser plus whole-vector debounce
module debounce_vetor
   import condicionador_botoes_pkg::*;
#(
   parameter int W               = BOTOES_W,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] entrada_i,
   output logic [W-1:0] estavel_o
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0]     sync1_q, sync2_q;
   logic [W-1:0]     cand_q, cand_d;
   logic [W-1:0]     estavel_q, estavel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any change of the synchronised vector restarts the count; the counter parks at its maximum.
   always_comb begin
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      estavel_d = estavel_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q == CNT_MAX) begin
         estavel_d = cand_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cand_q    <= '0;
         cnt_q     <= '0;
         estavel_q <= '0;
      end else begin
         sync1_q   <= entrada_i;
         sync2_q   <= sync1_q;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         estavel_q <= estavel_d;
      end
   end

   assign estavel_o = estavel_q;

endmodule

// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - turns raw board buttons into one validated play event per press
module condicionador_botoes
   import condicionador_botoes_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   condicionador_botoes_if.slave bus
);

   logic [BOTOES_W-1:0] estavel;
   logic [BOTOES_W-1:0] jogada_q, jogada_d;
   estado_t             estado_q, estado_d;

   debounce_vetor #(
      .W               (BOTOES_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock     (clock),
      .reset     (reset),
      .entrada_i (bus.botoes),
      .estavel_o (estavel)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= OCIOSO;
         jogada_q <= '0;
      end else begin
         estado_q <= estado_d;
         jogada_q <= jogada_d;
      end
   end

   // habilita is only looked at when leaving OCIOSO; a disabled press still waits for release.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         OCIOSO: begin
            if (estavel != '0) begin
               if (!is_one_hot(estavel))  estado_d = INVALIDA;
               else if (bus.habilita)     estado_d = REGISTRA;
               else                       estado_d = ESPERA_SOLTAR;
            end
         end
         REGISTRA:      estado_d = ESPERA_SOLTAR;
         INVALIDA:      estado_d = ESPERA_SOLTAR;
         ESPERA_SOLTAR: if (estavel == '0) estado_d = OCIOSO;
         default:       estado_d = OCIOSO;
      endcase
   end

   // A load from REGISTRA takes priority over a simultaneous clear.
   always_comb begin
      jogada_d = jogada_q;
      if (estado_q == REGISTRA) jogada_d = estavel;
      else if (bus.limpa)       jogada_d = '0;
   end

   always_comb begin
      bus.jogada_feita       = (estado_q == REGISTRA);
      bus.jogada_invalida    = (estado_q == INVALIDA);
      bus.db_estado          = estado_q;
      bus.jogada             = jogada_q;
      bus.db_botoes_estaveis = estavel;
   end

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - randomized scenario bench with a behavioural play-event model
module tb_condicionador_botoes;

   localparam int DBC = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;

   int checks = 0, errors = 0;
   int mon_diff = 0, overlap = 0, feita_cnt = 0, inval_cnt = 0;

   condicionador_botoes_if bus();

   condicionador_botoes #(.DEBOUNCE_CYCLES(DBC)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Reference: a level is accepted once sync2 (input delayed two edges) showed it DBC+1 edges in a row;
   // a press is judged on the first nonzero accepted level after an accepted all-released level.
   logic [3:0] hist[$] = '{4'h0, 4'h0};
   logic [3:0] s2q[$];
   logic [3:0] est_m = 0, jog_m = 0, load_m = 0, s2;
   bit         armed_m = 1, feita_m = 0, inval_m = 0, nf, ni, all_eq;

   initial begin : model
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) begin
            hist = '{4'h0, 4'h0}; s2q.delete();
            est_m = 0; jog_m = 0; load_m = 0; armed_m = 1; feita_m = 0; inval_m = 0;
         end else begin
            nf = 0; ni = 0;
            if (feita_m) jog_m = load_m;
            else if (bus.limpa) jog_m = 0;
            if (!(feita_m || inval_m)) begin
               if (armed_m) begin
                  if (est_m != 0) begin
                     armed_m = 0;
                     load_m  = est_m;
                     if ($countones(est_m) == 1) nf = bus.habilita;
                     else ni = 1;
                  end
               end else if (est_m == 0) begin
                  armed_m = 1;
               end
            end
            feita_m = nf; inval_m = ni;
            s2 = hist[0];
            hist.push_back(bus.botoes);
            void'(hist.pop_front());
            s2q.push_back(s2);
            if (s2q.size() > DBC + 1) void'(s2q.pop_front());
            if (s2q.size() == DBC + 1) begin
               all_eq = 1;
               foreach (s2q[i]) if (s2q[i] != s2) all_eq = 0;
               if (all_eq) est_m = s2;
            end
         end
      end
   end

   logic [3:0] exp_estado;
   bit         prev_pulse = 0;

   initial begin : monitor
      forever begin
         @(posedge clock);
         #1;
         exp_estado = feita_m ? 4'd1 : inval_m ? 4'd2 : armed_m ? 4'd0 : 4'd3;
         if ({bus.jogada, bus.jogada_feita, bus.jogada_invalida, bus.db_botoes_estaveis, bus.db_estado}
             !== {jog_m, feita_m, inval_m, est_m, exp_estado}) mon_diff++;
         if (bus.jogada_feita) feita_cnt++;
         if (bus.jogada_invalida) inval_cnt++;
         if ((bus.jogada_feita && bus.jogada_invalida) ||
             ((bus.jogada_feita || bus.jogada_invalida) && prev_pulse)) overlap++;
         prev_pulse = bus.jogada_feita || bus.jogada_invalida;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic drive(input logic [3:0] code, input int hold, output int first);
      first = -1;
      bus.botoes = code;
      for (int n = 1; n <= hold; n++) begin
         @(negedge clock);
         if (first < 0 && bus.jogada_feita) first = n;
      end
   endtask

   task automatic test_reset();
      reset = 0; bus.habilita = 0; bus.limpa = 0; bus.botoes = 0;
      cyc(3);
      checks++; if (bus.jogada !== 4'h0) begin errors++; $display("FAIL reset_jogada: got %h want 0", bus.jogada); end
      checks++; if (bus.jogada_feita !== 1'b0) begin errors++; $display("FAIL reset_feita: got %b want 0", bus.jogada_feita); end
      checks++; if (bus.jogada_invalida !== 1'b0) begin errors++; $display("FAIL reset_invalida: got %b want 0", bus.jogada_invalida); end
      checks++; if (bus.db_botoes_estaveis !== 4'h0) begin errors++; $display("FAIL reset_estaveis: got %h want 0", bus.db_botoes_estaveis); end
      checks++; if (bus.db_estado !== 4'h0) begin errors++; $display("FAIL reset_estado: got %h want 0", bus.db_estado); end
      reset = 1;
      mon_diff = 0;
   endtask

   task automatic test_single_press();
      int first, f0, i0;
      logic [3:0] code;
      code = 4'b0001 << $urandom_range(0, 3);
      f0 = feita_cnt; i0 = inval_cnt; mon_diff = 0;
      bus.habilita = 1;
      drive(code, 20, first);
      checks++; if (first !== 8) begin errors++; $display("FAIL single_latency: got %0d want 8", first); end
      checks++; if (feita_cnt - f0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", feita_cnt - f0); end
      checks++; if (inval_cnt - i0 !== 0) begin errors++; $display("FAIL single_invalida: got %0d want 0", inval_cnt - i0); end
      checks++; if (bus.jogada !== code) begin errors++; $display("FAIL single_jogada: got %h want %h", bus.jogada, code); end
      drive(4'h0, 10, first);
      checks++; if (mon_diff !== 0) begin errors++; $display("FAIL single_model: got %0d diffs want 0", mon_diff); end
   endtask

   task automatic test_bounce();
      int first, f0, i0;
      f0 = feita_cnt; i0 = inval_cnt; mon_diff = 0;
      for (int k = 0; k < 10; k++) begin
         drive(4'b0010, $urandom_range(1, DBC), first);
         drive(4'b0000, $urandom_range(1, DBC), first);
      end
      drive(4'h0, 10, first);
      checks++; if (feita_cnt - f0 + inval_cnt - i0 !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", feita_cnt - f0 + inval_cnt - i0); end
      checks++; if (mon_diff !== 0) begin errors++; $display("FAIL bounce_model: got %0d diffs want 0", mon_diff); end
      drive(4'b0010, 10, first);
      checks++; if (feita_cnt - f0 !== 1) begin errors++; $display("FAIL bounce_press: got %0d pulses want 1", feita_cnt - f0); end
      checks++; if (bus.jogada !== 4'b0010) begin errors++; $display("FAIL bounce_jogada: got %h want 2", bus.jogada); end
      drive(4'h0, 10, first);
   endtask

   task automatic test_two_buttons();
      int first, f0, i0;
      f0 = feita_cnt; i0 = inval_cnt; mon_diff = 0;
      drive(4'b0011, 10, first);
      checks++; if (inval_cnt - i0 !== 1) begin errors++; $display("FAIL two_invalida: got %0d want 1", inval_cnt - i0); end
      checks++; if (bus.jogada !== 4'b0010) begin errors++; $display("FAIL two_jogada: got %h want 2", bus.jogada); end
      drive(4'b1011, 10, first);
      drive(4'b0001, 10, first);
      checks++; if (inval_cnt - i0 !== 1 || feita_cnt - f0 !== 0) begin errors++; $display("FAIL two_held_changes: got inval=%0d feita=%0d want 1 0", inval_cnt - i0, feita_cnt - f0); end
      drive(4'h0, 10, first);
      checks++; if (mon_diff !== 0) begin errors++; $display("FAIL two_model: got %0d diffs want 0", mon_diff); end
   endtask

   task automatic test_hold_repress();
      int first, f0;
      f0 = feita_cnt; mon_diff = 0;
      drive(4'b1000, 100, first);
      checks++; if (feita_cnt - f0 !== 1) begin errors++; $display("FAIL hold_pulses: got %0d want 1", feita_cnt - f0); end
      drive(4'h0, 3, first);
      drive(4'b1000, 10, first);
      checks++; if (feita_cnt - f0 !== 1) begin errors++; $display("FAIL short_release: got %0d want 1", feita_cnt - f0); end
      drive(4'h0, $urandom_range(6, 10), first);
      drive(4'b1000, 10, first);
      checks++; if (feita_cnt - f0 !== 2) begin errors++; $display("FAIL long_release: got %0d want 2", feita_cnt - f0); end
      drive(4'h0, 10, first);
      checks++; if (mon_diff !== 0) begin errors++; $display("FAIL hold_model: got %0d diffs want 0", mon_diff); end
   endtask

   task automatic test_habilita_limpa();
      int first, f0;
      f0 = feita_cnt; mon_diff = 0;
      bus.habilita = 0;
      drive(4'b0001, 10, first);
      checks++; if (feita_cnt - f0 !== 0) begin errors++; $display("FAIL disabled_pulse: got %0d want 0", feita_cnt - f0); end
      checks++; if (bus.jogada !== 4'b1000) begin errors++; $display("FAIL disabled_jogada: got %h want 8", bus.jogada); end
      checks++; if (bus.db_estado !== 4'd3) begin errors++; $display("FAIL disabled_estado: got %0d want 3", bus.db_estado); end
      drive(4'h0, 10, first);
      bus.habilita = 1; bus.limpa = 1;
      cyc(1);
      bus.limpa = 0;
      checks++; if (bus.jogada !== 4'h0) begin errors++; $display("FAIL limpa_clear: got %h want 0", bus.jogada); end
      bus.botoes = 4'b0100;
      first = -1;
      for (int n = 1; n <= 20 && first < 0; n++) begin
         @(negedge clock);
         if (bus.jogada_feita) first = n;
      end
      bus.limpa = (first > 0);
      cyc(1);
      bus.limpa = 0;
      checks++; if (first !== 8) begin errors++; $display("FAIL limpa_race_latency: got %0d want 8", first); end
      checks++; if (bus.jogada !== 4'b0100) begin errors++; $display("FAIL limpa_race_jogada: got %h want 4", bus.jogada); end
      drive(4'h0, 10, first);
      checks++; if (mon_diff !== 0) begin errors++; $display("FAIL limpa_model: got %0d diffs want 0", mon_diff); end
   endtask

   task automatic test_reset_mid();
      int first, f0;
      mon_diff = 0;
      bus.botoes = 4'b0010;
      cyc(5);
      #2 reset = 0;
      #1;
      checks++; if (bus.jogada !== 4'h0) begin errors++; $display("FAIL mid_reset_jogada: got %h want 0", bus.jogada); end
      checks++; if ({bus.jogada_feita, bus.jogada_invalida} !== 2'b00) begin errors++; $display("FAIL mid_reset_pulses: got %b want 00", {bus.jogada_feita, bus.jogada_invalida}); end
      checks++; if (bus.db_botoes_estaveis !== 4'h0) begin errors++; $display("FAIL mid_reset_estaveis: got %h want 0", bus.db_botoes_estaveis); end
      checks++; if (bus.db_estado !== 4'h0) begin errors++; $display("FAIL mid_reset_estado: got %h want 0", bus.db_estado); end
      @(negedge clock);
      reset = 1;
      f0 = feita_cnt;
      drive(4'b0010, 20, first);
      checks++; if (first !== 8) begin errors++; $display("FAIL mid_reset_latency: got %0d want 8", first); end
      checks++; if (feita_cnt - f0 !== 1 || bus.jogada !== 4'b0010) begin errors++; $display("FAIL mid_reset_press: got %0d pulses jogada %h want 1 2", feita_cnt - f0, bus.jogada); end
      drive(4'h0, 10, first);
      checks++; if (mon_diff !== 0) begin errors++; $display("FAIL mid_reset_model: got %0d diffs want 0", mon_diff); end
   endtask

   task automatic test_random();
      int first, hold, sel, f0;
      logic [3:0] code;
      mon_diff = 0; overlap = 0; f0 = feita_cnt;
      for (int seg = 0; seg < 300; seg++) begin
         sel = $urandom_range(0, 3);
         if (sel == 0) code = 4'h0;
         else if (sel == 3) code = 4'($urandom_range(1, 15));
         else code = 4'b0001 << $urandom_range(0, 3);
         hold = $urandom_range(2, 12);
         bus.habilita = ($urandom_range(0, 3) != 0);
         bus.limpa = ($urandom_range(0, 7) == 0);
         bus.botoes = code;
         cyc(1);
         bus.limpa = 0;
         drive(code, hold - 1, first);
      end
      drive(4'h0, 12, first);
      checks++; if (mon_diff !== 0) begin errors++; $display("FAIL random_model: got %0d diffs want 0", mon_diff); end
      checks++; if (overlap !== 0) begin errors++; $display("FAIL random_pulse_spacing: got %0d want 0", overlap); end
      checks++; if (feita_cnt - f0 <= 0) begin errors++; $display("FAIL random_activity: got %0d pulses want >0", feita_cnt - f0); end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin : main
      test_reset();
      test_single_press();
      test_bounce();
      test_two_buttons();
      test_hold_repress();
      test_habilita_limpa();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
